serial_adder: RTL and testbench
===============================

SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 Parameter WIDTH, default 8, operand and sum width in bits; the block SHALL support WIDTH >= 1.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 start  input  1  request to begin an addition; sampled on rising clk edges.
REQ-005 operand_A  input  WIDTH  first addend; captured on the accepted start.
REQ-006 operand_B  input  WIDTH  second addend; captured on the accepted start.
REQ-007 carry_in  input  1  initial carry; captured on the accepted start.
REQ-008 busy  output  1  high while an addition is in progress.
REQ-009 done  output  1  one-cycle pulse marking a valid result.
REQ-010 sum  output  WIDTH  registered result, LSB = bit 0.
REQ-011 carry_out  output  1  registered final carry.

Function
REQ-012 The block SHALL compute {carry_out, sum} = operand_A + operand_B + carry_in, one bit per cycle, LSB first, through a single 1-bit full-add stage with a registered carry.
REQ-013 States SHALL be IDLE, SHIFT and DONE, with IDLE as the reset state.
REQ-014 IDLE with start=1: latch operand_A, operand_B and carry_in into internal shift and carry registers, clear the bit counter and go to SHIFT.
REQ-015 IDLE with start=0: remain in IDLE.
REQ-016 Each SHIFT cycle SHALL add the bit-0 positions of the A and B shift registers with the carry register.
REQ-017 Each SHIFT cycle SHALL shift the sum bit into the MSB of an internal result register (right shift) and shift A and B right by one.
REQ-018 Each SHIFT cycle SHALL load the carry register with the full-add carry and increment the bit counter.
REQ-019 Once WIDTH SHIFT cycles have completed, the FSM SHALL go to DONE and load the sum and carry_out outputs in that same edge.
REQ-020 The counter SHALL be ceil(log2(WIDTH+1)) bits wide, with a minimum of 1 bit, and SHALL NOT wrap within an operation.
REQ-021 DONE SHALL last exactly one cycle with done=1 and SHALL then return to IDLE unconditionally.
REQ-022 busy SHALL be 1 in SHIFT and 0 in IDLE and DONE.
REQ-023 done SHALL be 1 only in DONE.
REQ-024 Latency: with start accepted at edge k, busy=1 after edges k through k+WIDTH-1, and done=1 after edge k+WIDTH.
REQ-025 sum and carry_out SHALL change only on the edge entering DONE, and SHALL hold until the next completion.
REQ-026 start asserted in SHIFT or DONE SHALL be ignored; it is not queued.
REQ-027 Changes to operand_A, operand_B or carry_in after the start edge SHALL NOT affect the result in progress.
REQ-028 start held high continuously SHALL start a new operation in each IDLE cycle, giving a throughput of one result per WIDTH+2 cycles.

Reset
REQ-029 When rst_n=0 the block SHALL immediately, without waiting for clk, force state IDLE, busy=0, done=0, sum=0, carry_out=0, and clear the counter, carry register and shift registers.
REQ-030 A reset in mid-operation SHALL abort the operation with no done pulse, and the partial result SHALL be discarded.
REQ-031 After rst_n deasserts, the first rising edge with start=1 SHALL be accepted.

Verification
REQ-032 WIDTH=8, A=0x5A, B=0x33, carry_in=0, one-cycle start -> busy for 8 cycles, then done pulse with sum=0x8D, carry_out=0.
REQ-033 WIDTH=8, A=0xFF, B=0x01, carry_in=0 -> sum=0x00, carry_out=1; then A=0xFF, B=0xFF, carry_in=1 -> sum=0xFF, carry_out=1.
REQ-034 Start accepted with A=0x10, B=0x01; then start pulsed with A=0xAA during busy and operands changed mid-operation -> single done pulse with sum=0x11; the second start is ignored and sum holds 0x11 afterwards.
REQ-035 rst_n pulsed low asynchronously (between clk edges) in the 4th SHIFT cycle -> busy, done, sum and carry_out are 0 immediately, no done pulse follows, and the next start completes correctly.
REQ-036 WIDTH=1, A=1, B=1, carry_in=1 -> done after 2 edges with sum=1, carry_out=1.
REQ-037 Random regression for WIDTH in {1, 4, 8, 16} with start held high -> every result matches A+B+carry_in, one done per WIDTH+2 cycles.

Source files
------------

// File: rtl/serial_adder.sv
// Bit-serial ripple adder: one full-add per clock, LSB first, with a registered carry.
// Result and carry_out are loaded only on completion and then held until the next one.
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] operand_A,
  input  logic [WIDTH-1:0] operand_B,
  input  logic             carry_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out
);

  localparam int CNT_W = (WIDTH < 1) ? 1 : $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] shift_a;
  logic [WIDTH-1:0] shift_b;
  logic [WIDTH-1:0] result;
  logic [WIDTH-1:0] result_next;
  logic             carry;
  logic [CNT_W-1:0] count;
  logic [1:0]       fa;

  // Returns {carry, sum} of a single-bit full add.
  function automatic logic [1:0] full_add(input logic x, input logic y, input logic c);
    return {(x & y) | (x & c) | (y & c), x ^ y ^ c};
  endfunction

  // Sum bit enters at the MSB so that after WIDTH shifts bit 0 sits at the LSB;
  // written as a shift plus bit write so it also elaborates for WIDTH = 1.
  always_comb begin
    fa                   = full_add(shift_a[0], shift_b[0], carry);
    result_next          = result >> 1;
    result_next[WIDTH-1] = fa[0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      shift_a   <= '0;
      shift_b   <= '0;
      result    <= '0;
      carry     <= 1'b0;
      count     <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      sum       <= '0;
      carry_out <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            shift_a <= operand_A;
            shift_b <= operand_B;
            carry   <= carry_in;
            result  <= '0;
            count   <= '0;
            busy    <= 1'b1;
            state   <= SHIFT;
          end
        end
        SHIFT: begin
          result  <= result_next;
          shift_a <= shift_a >> 1;
          shift_b <= shift_b >> 1;
          carry   <= fa[1];
          count   <= count + 1'b1;
          if (count == LAST_BIT) begin
            sum       <= result_next;
            carry_out <= fa[1];
            busy      <= 1'b0;
            done      <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// Bench for serial_adder: four instances (WIDTH 1, 4, 8, 16), each shadowed by an
// arithmetic reference model compared every cycle, plus literal directed scenarios.
`timescale 1ns/1ps
module tb_serial_adder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  start_v;
  logic [3:0]  cin_v;
  logic [63:0] a_v;
  logic [63:0] b_v;
  logic [3:0]  busy_v;
  logic [3:0]  done_v;
  logic [3:0]  co_v;
  logic [63:0] sum_v;
  logic        check_en = 1'b0;
  int          n_checks = 0;
  int          n_fail   = 0;

  always #5 clk = ~clk;

  function automatic int width_of(input int i);
    case (i)
      0:       return 1;
      1:       return 4;
      2:       return 8;
      default: return 16;
    endcase
  endfunction

  for (genvar gi = 0; gi < 4; gi++) begin : g
    localparam int W = (gi == 0) ? 1 : (gi == 1) ? 4 : (gi == 2) ? 8 : 16;
    logic [W-1:0] a, b, s;
    logic         bz, dn, co;
    int           left;
    logic         m_busy, m_done;
    logic [W:0]   acc, m_res;

    assign a = a_v[gi*16 +: W];
    assign b = b_v[gi*16 +: W];
    assign busy_v[gi] = bz;
    assign done_v[gi] = dn;
    assign co_v[gi]   = co;
    assign sum_v[gi*16 +: 16] = 16'(s);

    serial_adder #(.WIDTH(W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start_v[gi]),
      .operand_A (a),
      .operand_B (b),
      .carry_in  (cin_v[gi]),
      .busy      (bz),
      .done      (dn),
      .sum       (s),
      .carry_out (co)
    );

    // Reference: an accepted start fixes A+B+cin; W busy cycles, one done cycle, then idle.
    always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        left   = 0;
        m_busy = 1'b0;
        m_done = 1'b0;
        acc    = '0;
        m_res  = '0;
      end else if (m_done) begin
        m_done = 1'b0;
      end else if (m_busy) begin
        left = left - 1;
        if (left == 0) begin
          m_busy = 1'b0;
          m_done = 1'b1;
          m_res  = acc;
        end
      end else if (start_v[gi]) begin
        acc    = (W+1)'(a) + (W+1)'(b) + (W+1)'(cin_v[gi]);
        left   = W;
        m_busy = 1'b1;
      end
    end

    always @(negedge clk) begin
      if (check_en && rst_n) begin
        n_checks++;
        if ({bz, dn, co, s} !== {m_busy, m_done, m_res}) begin
          n_fail++;
          $display("FAIL model_w%0d: actual busy/done/cout/sum %b/%b/%b/%h required %b/%b/%b/%h",
                   W, bz, dn, co, s, m_busy, m_done, m_res[W], m_res[W-1:0]);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic start_op(input int idx, input logic [15:0] a, input logic [15:0] b,
                          input logic cin);
    a_v[idx*16 +: 16] = a;
    b_v[idx*16 +: 16] = b;
    cin_v[idx]        = cin;
    start_v[idx]      = 1'b1;
    tick();
    start_v[idx]      = 1'b0;
  endtask

  // Counts edges (from the last one passed) until done shows, and busy cycles on the way.
  task automatic wait_done(input int idx, output int e, output int nbusy, output bit seen);
    e     = 0;
    nbusy = 0;
    seen  = 1'b0;
    while (!seen && e <= width_of(idx) + 4) begin
      if (done_v[idx]) seen = 1'b1;
      else begin
        if (busy_v[idx]) nbusy++;
        tick();
        e++;
      end
    end
  endtask

  task automatic run_op(input string name, input int idx, input logic [15:0] a,
                        input logic [15:0] b, input logic cin,
                        input logic [15:0] exp_sum, input logic exp_co);
    int e, nbusy;
    bit seen;
    start_op(idx, a, b, cin);
    wait_done(idx, e, nbusy, seen);
    check({name, "_done_seen"}, 32'(seen), 32'd1);
    check({name, "_latency"}, 32'(e), 32'(width_of(idx)));
    check({name, "_busy_cycles"}, 32'(nbusy), 32'(width_of(idx)));
    check({name, "_sum"}, 32'(sum_v[idx*16 +: 16]), 32'(exp_sum));
    check({name, "_cout"}, 32'(co_v[idx]), 32'(exp_co));
    tick();
    check({name, "_done_one_cycle"}, 32'(done_v[idx]), 32'd0);
    check({name, "_sum_hold"}, 32'(sum_v[idx*16 +: 16]), 32'(exp_sum));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: actual timeout required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int e, nbusy, ndone, m, w;
    bit seen;
    rst_n   = 1'b0;
    start_v = '0;
    cin_v   = '0;
    a_v     = '0;
    b_v     = '0;
    #1;
    check("reset_busy", 32'(busy_v), 32'd0);
    check("reset_done", 32'(done_v), 32'd0);
    check("reset_cout", 32'(co_v), 32'd0);
    check("reset_sum_lo", sum_v[31:0], 32'd0);
    check("reset_sum_hi", sum_v[63:32], 32'd0);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    check_en = 1'b1;
    @(posedge clk);
    #2;

    // Basic additions on WIDTH 8 and the WIDTH 1 corner.
    run_op("w8_5a_33", 2, 16'h5A, 16'h33, 1'b0, 16'h8D, 1'b0);
    run_op("w8_ff_01", 2, 16'hFF, 16'h01, 1'b0, 16'h00, 1'b1);
    run_op("w8_ff_ff_c", 2, 16'hFF, 16'hFF, 1'b1, 16'hFF, 1'b1);
    run_op("w1_1_1_c", 0, 16'h1, 16'h1, 1'b1, 16'h1, 1'b1);
    run_op("w4_9_8", 1, 16'h9, 16'h8, 1'b0, 16'h1, 1'b1);
    run_op("w16_big", 3, 16'hF0F0, 16'h0F10, 1'b0, 16'h0000, 1'b1);

    // Start during busy is ignored and operand changes do not disturb the running sum.
    start_op(2, 16'h10, 16'h01, 1'b0);
    tick();
    tick();
    a_v[47:32]  = 16'hAA;
    b_v[47:32]  = 16'h5C;
    start_v[2]  = 1'b1;
    tick();
    start_v[2]  = 1'b0;
    a_v[47:32]  = 16'h77;
    b_v[47:32]  = 16'hE1;
    cin_v[2]    = 1'b1;
    wait_done(2, e, nbusy, seen);
    check("ignore_done_seen", 32'(seen), 32'd1);
    check("ignore_sum", 32'(sum_v[47:32]), 32'h11);
    check("ignore_cout", 32'(co_v[2]), 32'd0);
    ndone = 0;
    repeat (12) begin
      tick();
      if (done_v[2]) ndone++;
    end
    check("ignore_no_second_done", 32'(ndone), 32'd0);
    check("ignore_sum_hold", 32'(sum_v[47:32]), 32'h11);

    // Asynchronous reset in the fourth shift cycle aborts without a done pulse.
    start_op(2, 16'h5A, 16'h33, 1'b0);
    tick();
    tick();
    tick();
    #2 rst_n = 1'b0;
    #1;
    check("abort_busy", 32'(busy_v[2]), 32'd0);
    check("abort_done", 32'(done_v[2]), 32'd0);
    check("abort_sum", 32'(sum_v[47:32]), 32'd0);
    check("abort_cout", 32'(co_v[2]), 32'd0);
    #1 rst_n = 1'b1;
    ndone = 0;
    repeat (12) begin
      tick();
      if (done_v[2] || busy_v[2]) ndone++;
    end
    check("abort_no_activity", 32'(ndone), 32'd0);
    run_op("after_abort", 2, 16'hC3, 16'h4E, 1'b1, 16'h12, 1'b1);

    // Start held high with fresh random operands every cycle.
    for (int idx = 0; idx < 4; idx++) begin
      w = width_of(idx);
      m = 10;
      ndone = 0;
      start_v[idx] = 1'b1;
      for (int c = 0; c < m * (w + 2); c++) begin
        a_v[idx*16 +: 16] = 16'($urandom);
        b_v[idx*16 +: 16] = 16'($urandom);
        cin_v[idx]        = 1'($urandom);
        tick();
        if (done_v[idx]) ndone++;
      end
      start_v[idx] = 1'b0;
      repeat (w + 3) begin
        tick();
        if (done_v[idx]) ndone++;
      end
      check($sformatf("stream_w%0d_done_count", w), 32'(ndone), 32'(m));
    end

    repeat (3) tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
